// File: rtl/fpu_cmp_scheduler.sv
// ============================================================================
// Module      : fpu_cmp_scheduler (with helper fpu_comparator)
// Description : Shares one subtract/compare unit between two requesters.
//               Round-robin arbitration, three-state issue FSM,
//               backpressured response port, wrapping completion counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

// Single shared subtractor: difference = a - b, sign = MSB of difference.
module fpu_comparator #(
  parameter int size = 32
) (
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size-1:0] difference,
  output logic            sign
);
  assign difference = a - b;
  assign sign       = difference[size-1];
endmodule

module fpu_cmp_scheduler #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [size-1:0] req0_a,
  input  logic [size-1:0] req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [size-1:0] req1_a,
  input  logic [size-1:0] req1_b,
  output logic            req1_ready,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [size-1:0] resp_diff,
  output logic            resp_lt,
  output logic            resp_eq,
  output logic            resp_gt,
  output logic [15:0]     op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_ptr;
  logic            r_id;
  logic [size-1:0] r_a;
  logic [size-1:0] r_b;
  logic [size-1:0] r_diff;
  logic            r_lt;
  logic            r_eq;
  logic            r_gt;
  logic            r_resp_valid;
  logic [15:0]     r_op_count;

  logic            w_idle;
  logic            w_gnt0;
  logic            w_gnt1;
  logic [size-1:0] w_diff;
  logic            w_sign;
  logic            w_zero;

  // The comparator only ever sees the latched operands, so requester inputs
  // may change freely once a grant has been taken.
  fpu_comparator #(.size(size)) u_cmp (
    .a          (r_a),
    .b          (r_b),
    .difference (w_diff),
    .sign       (w_sign)
  );

  assign w_zero = (w_diff == '0);

  // Requester 1 wins when it is alone or when the pointer favours it.
  assign w_idle = (r_state == S_IDLE);
  assign w_gnt1 = w_idle & req1_valid & (~req0_valid | r_ptr);
  assign w_gnt0 = w_idle & req0_valid & ~w_gnt1;

  // Ready is a same-cycle grant; forced low while reset is asserted.
  assign req0_ready = w_gnt0 & ~rst;
  assign req1_ready = w_gnt1 & ~rst;

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_diff  = r_diff;
  assign resp_lt    = r_lt;
  assign resp_eq    = r_eq;
  assign resp_gt    = r_gt;
  assign op_count   = r_op_count;

  // Issue FSM: grant/latch in IDLE, compare in EXEC, hold result in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= 1'b0;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_diff       <= '0;
      r_lt         <= 1'b0;
      r_eq         <= 1'b0;
      r_gt         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_op_count   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_a     <= w_gnt1 ? req1_a : req0_a;
            r_b     <= w_gnt1 ? req1_b : req0_b;
            r_id    <= w_gnt1;
            // Point at the requester that was not served.
            r_ptr   <= ~w_gnt1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Flags follow the raw sign bit; a-b overflow is not corrected.
          r_diff       <= w_diff;
          r_eq         <= w_zero;
          r_lt         <= w_sign & ~w_zero;
          r_gt         <= ~w_sign & ~w_zero;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_op_count   <= r_op_count + 16'd1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fpu_cmp_scheduler.sv
// ============================================================================
// Module      : tb_fpu_cmp_scheduler
// Description : Directed vectors and hand-written sequences for the shared
//               comparator scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_cmp_scheduler;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        req1_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] resp_diff;
  logic        resp_lt;
  logic        resp_eq;
  logic        resp_gt;
  logic [15:0] op_count;

  int n_chk;
  int n_bad;
  logic [15:0] exp_cnt;

  typedef struct {
    logic        v0;
    logic [31:0] a0;
    logic [31:0] b0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        id;
    logic [31:0] diff;
    logic        lt;
    logic        eq;
    logic        gt;
  } vec_t;

  vec_t vt[7];

  fpu_cmp_scheduler #(.size(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_diff  (resp_diff),
    .resp_lt    (resp_lt),
    .resp_eq    (resp_eq),
    .resp_gt    (resp_gt),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_resp(input string tag, input logic id, input logic [31:0] diff,
                          input logic lt, input logic eq, input logic gt);
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " resp_id"},    {31'd0, resp_id},    {31'd0, id});
    chk({tag, " resp_diff"},  resp_diff,           diff);
    chk({tag, " flags"},      {29'd0, resp_lt, resp_eq, resp_gt}, {29'd0, lt, eq, gt});
  endtask

  // One complete transaction from a table record: grant, EXEC, RESP, handshake.
  task automatic run_vec(input vec_t v);
    @(negedge clk);
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1;
    #1;
    chk("vec ready0", {31'd0, req0_ready}, {31'd0, ~v.id});
    chk("vec ready1", {31'd0, req1_ready}, {31'd0, v.id});
    @(negedge clk);
    // Scramble inputs after the grant; the in-flight result must not move.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~v.a0; req0_b = 32'h1234_5678;
    req1_a = ~v.a1; req1_b = 32'h8765_4321;
    #1;
    chk("vec exec resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk_resp("vec", v.id, v.diff, v.lt, v.eq, v.gt);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    #1;
    chk("vec done resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("vec op_count", {16'd0, op_count}, {16'd0, exp_cnt});
  endtask

  initial begin
    n_chk = 0; n_bad = 0; exp_cnt = 16'd0;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0;
    resp_ready = 1'b0;

    //            v0  a0            b0            v1  a1            b1            id  diff          lt eq gt
    vt[0] = '{1'b1, 32'd10,       32'd5,        1'b0, 32'd0,        32'd0,        1'b0, 32'd5,        1'b0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 32'd0,        32'd0,        1'b1, 32'hFFFFFFFB, 32'hFFFFFFF6, 1'b1, 32'd5,        1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b1, 32'd5,        32'd10,       1'b0, 32'd0,        32'd0,        1'b0, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 32'd0,        32'd0,        1'b1, 32'd7,        32'd7,        1'b1, 32'd0,        1'b0, 1'b1, 1'b0};
    vt[4] = '{1'b1, 32'h80000000, 32'd1,        1'b0, 32'd0,        32'd0,        1'b0, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1};
    vt[5] = '{1'b0, 32'd0,        32'd0,        1'b1, 32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b0};
    vt[6] = '{1'b1, 32'd0,        32'd0,        1'b0, 32'd0,        32'd0,        1'b0, 32'd0,        1'b0, 1'b1, 1'b0};

    // Reset state, with a request pending: ready must stay low.
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    chk("rst ready0", {31'd0, req0_ready}, 32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst op_count", {16'd0, op_count}, 32'd0);
    chk("rst resp_diff", resp_diff, 32'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle ready", {30'd0, req0_ready, req1_ready}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Contention after reset: pointer 0 favours req0, then req1, then back to req0.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; exp_cnt = 16'd0;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'd5;  req0_b = 32'd10;
    req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd10;
    #1;
    chk("cont ready0", {31'd0, req0_ready}, 32'd1);
    chk("cont ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req0_a = 32'd77;
    #1;
    chk("cont exec ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk_resp("cont first", 1'b0, 32'hFFFFFFFB, 1'b1, 1'b0, 1'b0);
    chk("cont resp ready1", {31'd0, req1_ready}, 32'd0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("cont second ready1", {31'd0, req1_ready}, 32'd1);
    chk("cont op_count 1", {16'd0, op_count}, 32'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_resp("cont second", 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);

    // Backpressure: five RESP cycles with both requesters waiting.
    req0_valid = 1'b1; req0_a = 32'd20; req0_b = 32'd3;
    req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk_resp("bp hold", 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
      chk("bp ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("bp op_count", {16'd0, op_count}, 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    chk("bp release resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp release op_count", {16'd0, op_count}, 32'd2);
    chk("ptr back ready0", {31'd0, req0_ready}, 32'd1);
    chk("ptr back ready1", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    #1;
    chk_resp("ptr back", 1'b0, 32'd17, 1'b0, 1'b0, 1'b1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    exp_cnt = 16'd3;
    #1;
    chk("cont op_count 3", {16'd0, op_count}, 32'd3);

    // Reset while a request sits in EXEC: outputs clear without a clock edge.
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'd3; req1_b = 32'd1;
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk("rexec op_count", {16'd0, op_count}, 32'd0);
    chk("rexec resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rexec id/flags", {28'd0, resp_id, resp_lt, resp_eq, resp_gt}, 32'd0);
    chk("rexec resp_diff", resp_diff, 32'd0);
    @(negedge clk);
    rst = 1'b0; exp_cnt = 16'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk("rexec no resp", {31'd0, resp_valid}, 32'd0);
    end
    run_vec(vt[0]);

    // Counter wrap: preload near the top, then two completions.
    @(negedge clk);
    force dut.r_op_count = 16'hFFFE;
    #1;
    release dut.r_op_count;
    #1;
    chk("wrap preload", {16'd0, op_count}, 32'h0000FFFE);
    exp_cnt = 16'hFFFE;
    run_vec(vt[3]);
    run_vec(vt[4]);
    chk("wrap zero", {16'd0, op_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
